// File: rtl/integrated_mem_rf_alu_flag_pkg.sv
// rtl/integrated_mem_rf_alu_flag_pkg.sv - shared encodings for the memory/RF/ALU/flag integration block
//
// Holds the ALU operation codes, register-file write-source codes,
// flag bit positions inside the {N,Z,P} register and the opcode
// that makes the branch condition unconditional.
package integrated_mem_rf_alu_flag_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOR = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        RWS_ALU   = 3'b000,
        RWS_MD    = 3'b001,
        RWS_UPPER = 3'b010,
        RWS_PC    = 3'b011,
        RWS_SIGNE = 3'b100
    } rwsrc_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;

    localparam logic [3:0] OP_ALWAYS = 4'hF;

endpackage

// File: rtl/integrated_mem_rf_alu_flag_alu16.sv
// rtl/integrated_mem_rf_alu_flag_alu16.sv - 16-bit combinational ALU
//
// Ports:
//   a   in  16  operand A
//   b   in  16  operand B (shift amount taken from b[3:0])
//   op  in  3   operation, alu_op_e encoding
//   y   out 16  result, wraps modulo 2^16, carry discarded
module alu16
    import integrated_mem_rf_alu_flag_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  op,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOR: y = ~(a | b);
            ALU_SHL: y = a << b[3:0];
            ALU_SHR: y = a >> b[3:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/integrated_mem_rf_alu_flag.sv
// rtl/integrated_mem_rf_alu_flag.sv - main memory, register file, ALU datapath registers and flag unit
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   MW, MA, MWD, LM   memory write enable / address / data / data select (1 = register B)
//   Write, MD         MD load enable and the memory-data register
//   RW, WA, RWSrc     register-file write enable / address / source select
//   PC, upper, signE  register-file write sources (signE is also ALU operand B)
//   r1A, r2A          register-file read addresses feeding A and B
//   SrcB, ALUOp       ALU operand B select and operation
//   FU                flag update enable
//   CC, Op, Perform   condition mask {N,Z,P}, opcode and branch-condition result
module integrated_mem_rf_alu_flag
    import integrated_mem_rf_alu_flag_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MW,
    input  logic [15:0] MA,
    input  logic [15:0] MWD,
    input  logic        LM,
    input  logic        Write,
    output logic [15:0] MD,
    input  logic        RW,
    input  logic [3:0]  WA,
    input  logic [2:0]  RWSrc,
    input  logic [15:0] PC,
    input  logic [15:0] upper,
    input  logic [15:0] signE,
    input  logic [3:0]  r1A,
    input  logic [3:0]  r2A,
    input  logic        SrcB,
    input  logic [2:0]  ALUOp,
    input  logic        FU,
    input  logic [2:0]  CC,
    input  logic [3:0]  Op,
    output logic        Perform
);

    localparam int MEM_WORDS = 1 << MEM_AW;

    logic [15:0] mem [MEM_WORDS];
    logic [15:0] rf  [16];

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] aluout;
    logic [2:0]  flags;

    logic [MEM_AW-1:0] maddr;
    logic [15:0]       mem_wdata;
    logic [15:0]       alu_b;
    logic [15:0]       alu_y;
    logic [15:0]       rf_wdata;
    logic [2:0]        flags_next;

    // Upper address bits beyond the implemented memory are ignored.
    generate
        if (MEM_AW < 16) begin : g_ma_hi
            logic unused_ma_hi;
            assign unused_ma_hi = ^MA[15:MEM_AW];
        end
    endgenerate

    assign maddr     = MA[MEM_AW-1:0];
    assign mem_wdata = LM ? b_reg : MWD;
    assign alu_b     = SrcB ? signE : b_reg;

    alu16 u_alu (
        .a  (a_reg),
        .b  (alu_b),
        .op (ALUOp),
        .y  (alu_y)
    );

    always_comb begin
        rf_wdata = '0;
        case (rwsrc_e'(RWSrc))
            RWS_ALU:   rf_wdata = aluout;
            RWS_MD:    rf_wdata = MD;
            RWS_UPPER: rf_wdata = upper;
            RWS_PC:    rf_wdata = PC;
            RWS_SIGNE: rf_wdata = signE;
            default:   rf_wdata = '0;
        endcase
    end

    // Flags come from the already-registered ALUOut, so exactly one is set.
    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_N] = aluout[15];
        flags_next[FLAG_Z] = (aluout == 16'h0000);
        flags_next[FLAG_P] = !aluout[15] && (aluout != 16'h0000);
    end

    // Memory has no reset; a reset edge still blocks the write.
    always_ff @(posedge CLK) begin
        if (!RST && MW) begin
            mem[maddr] <= mem_wdata;
        end
    end

    // Write-first: a same-edge write at MA is forwarded into MD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MD <= '0;
        end else if (Write) begin
            MD <= MW ? mem_wdata : mem[maddr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else if (RW) begin
            rf[WA] <= rf_wdata;
        end
    end

    // A/B read the pre-edge RF contents (read-before-write).
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg  <= '0;
            b_reg  <= '0;
            aluout <= '0;
            flags  <= '0;
        end else begin
            a_reg  <= rf[r1A];
            b_reg  <= rf[r2A];
            aluout <= alu_y;
            if (FU) begin
                flags <= flags_next;
            end
        end
    end

    assign Perform = (Op == OP_ALWAYS) || (|(CC & flags));

endmodule

// File: tb/tb_integrated_mem_rf_alu_flag.sv
// tb/tb_integrated_mem_rf_alu_flag.sv - self-checking bench for integrated_mem_rf_alu_flag
module tb_integrated_mem_rf_alu_flag;

    localparam int MEM_AW = 10;

    logic        CLK = 1'b0;
    logic        RST, MW, LM, Write, RW, SrcB, FU;
    logic [15:0] MA, MWD, PC, upper, signE, MD;
    logic [3:0]  WA, r1A, r2A, Op;
    logic [2:0]  RWSrc, ALUOp, CC;
    logic        Perform;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    integrated_mem_rf_alu_flag #(.MEM_AW(MEM_AW)) dut (
        .CLK(CLK), .RST(RST), .MW(MW), .MA(MA), .MWD(MWD), .LM(LM),
        .Write(Write), .MD(MD), .RW(RW), .WA(WA), .RWSrc(RWSrc),
        .PC(PC), .upper(upper), .signE(signE), .r1A(r1A), .r2A(r2A),
        .SrcB(SrcB), .ALUOp(ALUOp), .FU(FU), .CC(CC), .Op(Op),
        .Perform(Perform)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- table-driven directed sequence ----------------
    typedef struct {
        logic        rst, mw, lm, wr, rw, srcb, fu, chk;
        logic [15:0] ma, mwd, pc, upper, signe;
        logic [3:0]  wa, r1a, r2a, op;
        logic [2:0]  rwsrc, aluop, cc;
        logic [15:0] e_md, e_alu;
        logic [2:0]  e_fl;
        logic        e_perf;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;

    task automatic push();
        tbl.push_back(cur);
        cur.rst = 0; cur.mw = 0; cur.rw = 0; cur.wr = 0; cur.fu = 0; cur.chk = 0;
    endtask

    task automatic expect_row(input logic [15:0] md, input logic [15:0] alu,
                              input logic [2:0] fl, input logic perf);
        cur.chk = 1; cur.e_md = md; cur.e_alu = alu; cur.e_fl = fl; cur.e_perf = perf;
    endtask

    task automatic drive_vec(input vec_t v);
        RST = v.rst; MW = v.mw; MA = v.ma; MWD = v.mwd; LM = v.lm; Write = v.wr;
        RW = v.rw; WA = v.wa; RWSrc = v.rwsrc; PC = v.pc; upper = v.upper;
        signE = v.signe; r1A = v.r1a; r2A = v.r2a; SrcB = v.srcb; ALUOp = v.aluop;
        FU = v.fu; CC = v.cc; Op = v.op;
    endtask

    // ---------------- reference model ----------------
    int mem_m[int];
    int rf_m[16];
    int a_m, b_m, alu_m, md_m, fl_m;

    function automatic int alu_ref(input int op, input int x, input int y);
        case (op)
            0: return (x + y) % 65536;
            1: return (x - y + 65536) % 65536;
            2: return x & y;
            3: return x | y;
            4: return x ^ y;
            5: return 65535 - (x | y);
            6: return (x << (y % 16)) % 65536;
            default: return x >> (y % 16);
        endcase
    endfunction

    function automatic int flags_ref(input int v);
        if (v >= 32768) return 4;
        if (v == 0) return 2;
        return 1;
    endfunction

    task automatic model_edge();
        int addr, wd, na, nb, nalu, nmd, src;
        if (RST) begin
            md_m = 0; a_m = 0; b_m = 0; alu_m = 0; fl_m = 0;
            for (int i = 0; i < 16; i++) rf_m[i] = 0;
        end else begin
            addr = int'(MA) % (1 << MEM_AW);
            wd   = LM ? b_m : int'(MWD);
            nmd  = md_m;
            if (Write) nmd = MW ? wd : (mem_m.exists(addr) ? mem_m[addr] : 0);
            na   = rf_m[r1A];
            nb   = rf_m[r2A];
            nalu = alu_ref(int'(ALUOp), a_m, SrcB ? int'(signE) : b_m);
            if (FU) fl_m = flags_ref(alu_m);
            if (MW) mem_m[addr] = wd;
            if (RW) begin
                case (RWSrc)
                    3'd0: src = alu_m;
                    3'd1: src = md_m;
                    3'd2: src = int'(upper);
                    3'd3: src = int'(PC);
                    3'd4: src = int'(signE);
                    default: src = 0;
                endcase
                rf_m[WA] = src;
            end
            a_m = na; b_m = nb; alu_m = nalu; md_m = nmd;
        end
    endtask

    initial begin
        cur = '{default: '0};

        cur.rst = 1; cur.cc = 3'b111; cur.op = 4'h0;
        expect_row(16'h0000, 16'h0000, 3'b000, 1'b0); push();             // reset, Op=0
        cur.rst = 1; cur.op = 4'hF;
        expect_row(16'h0000, 16'h0000, 3'b000, 1'b1); push();             // reset, Op=F
        cur.op = 4'h0; cur.mw = 1; cur.ma = 16'h0000; cur.mwd = 16'h0010;
        cur.rw = 1; cur.wa = 4'd0; cur.rwsrc = 3'd3; cur.pc = 16'd1; cur.r2a = 4'd1;
        push();                                                           // mem0=0x10, RF0=1
        cur.rw = 1; cur.wa = 4'd1; cur.pc = 16'd0; cur.wr = 1; push();    // RF1=0, MD=0x10
        push();                                                           // ALUOut = 1+0
        cur.fu = 1; cur.cc = 3'b111;
        expect_row(16'h0010, 16'h0001, 3'b001, 1'b1); push();
        cur.cc = 3'b100; cur.mw = 1; cur.mwd = 16'h0016; cur.wr = 1;
        expect_row(16'h0016, 16'h0001, 3'b001, 1'b0); push();             // write-first into MD
        cur.srcb = 1; cur.signe = 16'd4; cur.mw = 1; cur.mwd = 16'h0004; cur.wr = 1;
        expect_row(16'h0004, 16'h0005, 3'b001, 1'b0); push();             // A + signE
        cur.mw = 1; cur.mwd = 16'h001F; push();                           // MD holds with Write=0
        cur.lm = 1; cur.wr = 1; cur.fu = 1; cur.cc = 3'b111;
        expect_row(16'h001F, 16'h0005, 3'b001, 1'b1); push();             // LM=1, MW=0: no write
        cur.mw = 1; cur.wr = 1; cur.srcb = 0;
        expect_row(16'h0000, 16'h0001, 3'b001, 1'b1); push();             // mem0 <= B (=0)
        cur.r1a = 4'd1; cur.r2a = 4'd0; cur.aluop = 3'd1;
        cur.mw = 1; cur.ma = 16'h0003; cur.mwd = 16'hBEEF; cur.lm = 0; push();
        expect_row(16'h0000, 16'hFFFF, 3'b001, 1'b1); push();             // 0 - 1 wraps
        cur.fu = 1; cur.cc = 3'b010;
        expect_row(16'h0000, 16'hFFFF, 3'b100, 1'b0); push();             // N only
        cur.r1a = 4'd0; cur.r2a = 4'd0; push();
        push();                                                           // 1 - 1
        cur.fu = 1;
        expect_row(16'h0000, 16'h0000, 3'b010, 1'b1); push();             // Z with CC=010
        cur.rst = 1; cur.rw = 1; cur.wa = 4'd0; cur.rwsrc = 3'd3; cur.pc = 16'd7;
        cur.cc = 3'b111; cur.op = 4'h0;
        expect_row(16'h0000, 16'h0000, 3'b000, 1'b0); push();             // reset beats RW
        cur.rst = 1; cur.op = 4'hF;
        expect_row(16'h0000, 16'h0000, 3'b000, 1'b1); push();
        cur.op = 4'h0; cur.r2a = 4'd1; cur.aluop = 3'd3; cur.ma = 16'h0403; push();
        push();
        cur.fu = 1; cur.cc = 3'b010;
        expect_row(16'h0000, 16'h0000, 3'b010, 1'b1); push();             // RF reads are 0
        cur.wr = 1;
        expect_row(16'hBEEF, 16'h0000, 3'b010, 1'b1); push();             // mem kept, MA aliases

        for (int i = 0; i < tbl.size(); i++) begin
            drive_vec(tbl[i]);
            @(posedge CLK);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d MD", i), MD, tbl[i].e_md);
                check($sformatf("vec%0d ALUOut", i), dut.aluout, tbl[i].e_alu);
                check($sformatf("vec%0d flags", i), {13'd0, dut.flags}, {13'd0, tbl[i].e_fl});
                check($sformatf("vec%0d Perform", i), {15'd0, Perform}, {15'd0, tbl[i].e_perf});
            end
        end

        // ---------------- randomized phase against the model ----------------
        cur = '{default: '0};
        drive_vec(cur);
        RST = 1;
        model_edge();
        @(posedge CLK); #1;
        RST = 0;
        for (int i = 0; i < 16; i++) begin
            MW = 1; LM = 0; MA = 16'(i); MWD = 16'($urandom);
            model_edge();
            @(posedge CLK); #1;
        end
        for (int n = 0; n < 600; n++) begin
            RST   = ($urandom_range(0, 63) == 0);
            MW    = 1'($urandom_range(0, 1));
            MA    = 16'($urandom) & 16'hFC0F;
            MWD   = 16'($urandom);
            LM    = 1'($urandom_range(0, 1));
            Write = 1'($urandom_range(0, 1));
            RW    = 1'($urandom_range(0, 1));
            WA    = 4'($urandom);
            RWSrc = 3'($urandom);
            PC    = 16'($urandom);
            upper = 16'($urandom);
            signE = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            r1A   = 4'($urandom);
            r2A   = 4'($urandom);
            SrcB  = 1'($urandom_range(0, 1));
            ALUOp = 3'($urandom);
            FU    = 1'($urandom_range(0, 1));
            CC    = 3'($urandom);
            Op    = 4'($urandom);
            model_edge();
            @(posedge CLK); #1;
            check($sformatf("rnd%0d MD", n), MD, 16'(md_m));
            check($sformatf("rnd%0d ALUOut", n), dut.aluout, 16'(alu_m));
            check($sformatf("rnd%0d flags", n), {13'd0, dut.flags}, 16'(fl_m));
            check($sformatf("rnd%0d Perform", n), {15'd0, Perform},
                  ((Op == 4'hF) || ((int'(CC) & fl_m) != 0)) ? 16'd1 : 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
